// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM that sequences the shared
// datapath through fetch/decode/execute/writeback and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    output logic [3:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        PCEn,
    output logic        IllegalOp,
    output logic [3:0]  State,
    output logic [31:0] InstrCount
);
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1111;
    localparam logic [3:0] ALU_SRL = 4'b1110;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTEXEC   = 4'd6,
        RTWB     = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  op_q;
    logic [3:0]  alu_q;
    logic [31:0] instr_cnt;
    logic        funct_ok;
    logic [3:0]  funct_alu;
    logic        pc_write, pc_write_cond;
    logic        retire;

    assign State      = state;
    assign InstrCount = instr_cnt;
    assign PCEn       = pc_write | (pc_write_cond & Zero);

    // Last cycle of every legal instruction; the count bumps on the edge leaving it.
    assign retire = (state == MEMWB) || (state == MEMWR) || (state == RTWB) ||
                    (state == BRANCH) || (state == ADDIWB) || (state == JUMP);

    // Map R-type funct to an ALU operation and flag unsupported functs.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100110: funct_alu = ALU_XOR;
            6'b000010: funct_alu = ALU_SRL;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // State register plus the opcode/ALU-op latches captured in DECODE and the retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            op_q      <= '0;
            alu_q     <= '0;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                op_q  <= Opcode;
                alu_q <= funct_alu;
            end
            if (retire)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end

    // Next-state selection and Moore outputs; everything idles low except the ADD default.
    always_comb begin
        state_nxt     = FETCH;
        ALUControl    = ALU_ADD;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        IllegalOp     = 1'b0;
        case (state)
            FETCH: begin
                MemRead   = 1'b1;
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b01;
                pc_write  = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                // Precompute the branch target while the opcode is examined.
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RT: begin
                        if (funct_ok) state_nxt = RTEXEC;
                        else          IllegalOp = 1'b1;
                    end
                    OP_BEQ:  state_nxt = BRANCH;
                    OP_ADDI: state_nxt = ADDIEXEC;
                    OP_J:    state_nxt = JUMP;
                    default: IllegalOp = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = (op_q == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD      = 1'b1;
                MemRead   = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            RTEXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_q;
                state_nxt  = RTWB;
            end
            RTWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUControl    = ALU_SUB;
                pc_write_cond = 1'b1;
                PCSource      = 2'b01;
            end
            ADDIEXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                PCSource = 2'b10;
            end
            // Unused encodings fall back to FETCH with every strobe idle.
            default: state_nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode, Funct;
    logic        Zero;
    logic [3:0]  ALUControl;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic        PCEn, IllegalOp;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCEn(PCEn),
        .IllegalOp(IllegalOp), .State(State), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] outs;
        logic [31:0] cnt;
        int          st;
    } rec_t;

    rec_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mcount = 32'd0;

    // Expected Moore outputs per state, packed as
    // {ALUControl, ALUSrcA, ALUSrcB, PCSource, IorD, MemRead, MemWrite, IRWrite,
    //  RegDst, MemtoReg, RegWrite, PCEn, IllegalOp, State}
    function automatic logic [21:0] exp_outs(input int st, input logic [3:0] rt_alu,
                                             input logic z, input bit ill);
        logic [3:0] alu = 4'b0010;
        logic       sa = 0, iord = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, pce = 0, il = 0;
        logic [1:0] sb = 2'b00, pcs = 2'b00;
        case (st)
            0:  begin sb = 2'b01; mr = 1; irw = 1; pce = 1; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin iord = 1; mr = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; alu = rt_alu; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; alu = 4'b0110; pcs = 2'b01; pce = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; end
            11: begin pcs = 2'b10; pce = 1; end
            default: ;
        endcase
        return {alu, sa, sb, pcs, iord, mr, mw, irw, rd, m2r, rw, pce, il, st[3:0]};
    endfunction

    function automatic void push(input int st, input logic [3:0] rt_alu, input logic z, input bit ill);
        rec_t r;
        r.outs = exp_outs(st, rt_alu, z, ill);
        r.cnt  = mcount;
        r.st   = st;
        q.push_back(r);
    endfunction

    // Drive one instruction (starting in FETCH) and queue its per-cycle expectations.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic [3:0] rt_alu, input bit ill, output int len);
        int seq[6];
        seq = '{0, 1, 0, 0, 0, 0};
        len = 2;
        if (!ill) begin
            case (op)
                6'b100011: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; len = 5; end
                6'b101011: begin seq[2] = 2; seq[3] = 5; len = 4; end
                6'b000000: begin seq[2] = 6; seq[3] = 7; len = 4; end
                6'b000100: begin seq[2] = 8; len = 3; end
                6'b001000: begin seq[2] = 9; seq[3] = 10; len = 4; end
                6'b000010: begin seq[2] = 11; len = 3; end
                default: ;
            endcase
        end
        Opcode = op; Funct = fn; Zero = z;
        for (int i = 0; i < len; i++) push(seq[i], rt_alu, z, ill);
        if (!ill) mcount = mcount + 32'd1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [3:0] rt_alu, input bit ill);
        int len;
        issue(op, fn, z, rt_alu, ill, len);
        cycles(len);
    endtask

    // Monitor: every cycle with a pending expectation, compare the full output vector and count.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t r;
            logic [21:0] act;
            r = q.pop_front();
            act = {ALUControl, ALUSrcA, ALUSrcB, PCSource, IorD, MemRead, MemWrite, IRWrite,
                   RegDst, MemtoReg, RegWrite, PCEn, IllegalOp, State};
            checks++;
            if (act !== r.outs) begin
                errors++;
                $display("FAIL outs@st%0d: got %h expected %h", r.st, act, r.outs);
            end
            checks++;
            if (InstrCount !== r.cnt) begin
                errors++;
                $display("FAIL count@st%0d: got %h expected %h", r.st, InstrCount, r.cnt);
            end
        end
    end

    initial begin
        int len;
        reset = 1'b1; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0;
        cycles(1);
        push(0, 4'b0010, 1'b0, 1'b0);          // held in reset: FETCH, count 0
        cycles(1);
        reset = 1'b0;

        run(6'b100011, 6'd0, 1'b0, 4'b0010, 1'b0);      // lw: 0,1,2,3,4
        run(6'b000000, 6'b100110, 1'b0, 4'b1111, 1'b0); // xor
        run(6'b000000, 6'b000010, 1'b0, 4'b1110, 1'b0); // srl
        run(6'b000100, 6'd0, 1'b1, 4'b0010, 1'b0);      // beq taken
        run(6'b000100, 6'd0, 1'b0, 4'b0010, 1'b0);      // beq not taken
        run(6'b111111, 6'd0, 1'b0, 4'b0010, 1'b1);      // illegal opcode
        run(6'b000000, 6'b000000, 1'b0, 4'b0010, 1'b1); // illegal funct
        run(6'b101011, 6'd0, 1'b0, 4'b0010, 1'b0);      // sw
        run(6'b001000, 6'd0, 1'b0, 4'b0010, 1'b0);      // addi
        run(6'b000000, 6'b100000, 1'b0, 4'b0010, 1'b0); // add
        run(6'b000000, 6'b100010, 1'b0, 4'b0110, 1'b0); // sub
        run(6'b000000, 6'b100100, 1'b0, 4'b0000, 1'b0); // and
        run(6'b000000, 6'b100101, 1'b0, 4'b0001, 1'b0); // or
        run(6'b000010, 6'd0, 1'b0, 4'b0010, 1'b0);      // j

        // Reset while in MEMRD: abandon the lw, no write strobe afterwards.
        Opcode = 6'b100011; Funct = 6'd0; Zero = 1'b0;
        push(0, 4'b0010, 1'b0, 1'b0);
        push(1, 4'b0010, 1'b0, 1'b0);
        push(2, 4'b0010, 1'b0, 1'b0);
        push(3, 4'b0010, 1'b0, 1'b0);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        mcount = 32'd0;
        run(6'b101011, 6'd0, 1'b0, 4'b0010, 1'b0);      // sw after reset, count starts at 0

        // Counter wrap: preset to all-ones, retire a j, expect 0.
        force dut.instr_cnt = 32'hFFFF_FFFF;
        mcount = 32'hFFFF_FFFF;
        issue(6'b000010, 6'd0, 1'b0, 4'b0010, 1'b0, len);
        cycles(1);
        release dut.instr_cnt;
        cycles(len - 1);
        run(6'b001000, 6'd0, 1'b0, 4'b0010, 1'b0);      // addi seen with count 0

        cycles(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state updates occur on this edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  instruction bits [31:26], sampled only in DECODE.
REQ-005 Funct  input  6  instruction bits [5:0], sampled only in DECODE.
REQ-006 Zero  input  1  ALU zero flag, used only in BRANCH.
REQ-007 ALUControl  output  4  ALU operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 XOR, 1110 SRL.
REQ-008 ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = register A.
REQ-009 ALUSrcB  output  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 PCSource  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-011 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite  output  1 each  datapath strobes.
REQ-012 PCEn  output  1  PC write enable, equal to PCWrite OR (PCWriteCond AND Zero), combinational.
REQ-013 IllegalOp  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-014 State  output  4  current state encoding, for debug.
REQ-015 InstrCount  output  32  count of retired instructions.

Function
REQ-016 The FSM SHALL be a Moore machine with these states: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 RTEXEC, 7 RTWB, 8 BRANCH, 9 ADDIEXEC, 10 ADDIWB, 11 JUMP.
REQ-017 Encodings 12-15 SHALL transition to FETCH on the next edge, with all strobes at 0.
REQ-018 Any strobe not listed for a state SHALL be 0 in that state.
REQ-019 ALUControl SHALL be 0010 in states where it is not specified.
REQ-020 FETCH SHALL drive MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=0010, PCSource=00 and PCWrite=1, then go to DECODE.
REQ-021 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUControl=0010 and SHALL branch on Opcode as follows:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) with a supported funct -> RTEXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXEC
  - 000010 (j) -> JUMP
  - anything else -> FETCH, with IllegalOp=1 for exactly that DECODE cycle
REQ-022 Supported funct values: 100000 ADD->0010, 100010 SUB->0110, 100100 AND->0000, 100101 OR->0001, 100110 XOR->1111, 000010 SRL->1110.
REQ-023 The funct mapping SHALL be latched into an internal register in DECODE and driven on ALUControl during RTEXEC.
REQ-024 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=0010, then go to MEMRD for lw or MEMWR for sw; the opcode is latched in DECODE.
REQ-025 MEMRD SHALL drive IorD=1, MemRead=1, then go to MEMWB.
REQ-026 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, then go to FETCH.
REQ-027 MEMWR SHALL drive IorD=1, MemWrite=1, then go to FETCH.
REQ-028 RTEXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and the latched ALUControl, then go to RTWB.
REQ-029 RTWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-030 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl=0110, PCWriteCond=1, PCSource=01, then go to FETCH; PCEn SHALL equal Zero in this state.
REQ-031 ADDIEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=0010, then go to ADDIWB.
REQ-032 ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-033 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-034 InstrCount SHALL increment by 1 on the edge leaving MEMWB, MEMWR, RTWB, BRANCH, ADDIWB or JUMP.
REQ-035 InstrCount SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-036 Illegal instructions SHALL NOT increment InstrCount.
REQ-037 Instruction latency SHALL be 5 cycles for lw; 4 cycles for sw, R-type and addi; 3 cycles for beq and j; 2 cycles for an illegal instruction.

Reset
REQ-038 While reset=1 at a rising edge, State SHALL become FETCH, InstrCount SHALL become 0, and the latched opcode and ALUControl registers SHALL become 0.
REQ-039 Reset SHALL take priority over every transition, including when asserted mid-instruction; that instruction SHALL be abandoned with no write strobe in the following cycle.
REQ-040 In the first cycle after reset, the outputs SHALL be the FETCH values.

Verification
REQ-041 Opcode=100011 after reset -> State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; InstrCount=1.
REQ-042 Opcode=000000 with Funct=100110, then with Funct=000010 -> ALUControl=1111 in the first RTEXEC and 1110 in the second; InstrCount=2.
REQ-043 Opcode=000100 run twice, with Zero=1 then Zero=0 in BRANCH -> PCEn=1 then PCEn=0; PCSource=01 both times.
REQ-044 Opcode=111111, or Opcode=000000 with Funct=000000 -> IllegalOp pulses 1 cycle in DECODE; next State=0; InstrCount unchanged.
REQ-045 reset asserted while in MEMRD -> next State=0, InstrCount=0, RegWrite and MemWrite stay 0.
REQ-046 InstrCount forced near 0xFFFFFFFF then one j retired -> InstrCount=0.
